// File: rtl/rv_pkg.sv
// Shared core constants for the integer register file and its scoreboard.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for long-latency writebacks, with a registered
// population count maintained incrementally alongside them.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      busy_cnt
);

  logic             set_ok;
  logic             clr_ok;
  logic             inc;
  logic             dec;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;

  // Priority, lowest to highest: write clear, set (newer producer wins), flush.
  always_comb begin
    set_ok   = sb_set && (sb_addr != AW'(ZERO_REG)) && !flush;
    clr_ok   = we && (wa != AW'(ZERO_REG));
    inc      = set_ok && !pending[sb_addr];
    dec      = clr_ok && pending[wa] && !(set_ok && (sb_addr == wa));
    pend_nxt = pending;
    if (clr_ok) pend_nxt[wa] = 1'b0;
    if (set_ok) pend_nxt[sb_addr] = 1'b1;
    if (flush)  pend_nxt = '0;
    pend_nxt[ZERO_REG] = 1'b0;
    cnt_nxt = busy_cnt;
    if (flush)              cnt_nxt = '0;
    else if (inc && !dec)   cnt_nxt = busy_cnt + 1'b1;
    else if (dec && !inc)   cnt_nxt = busy_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with hardwired x0, optional
// write-to-read bypass and a pending-writeback scoreboard for hazard stalls.
module reg_file_sb
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = 1 << REG_AW,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  // Every request presented on a clock edge takes effect on that edge;
  // there is no valid/ready back-pressure on any port.
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (we && (wa != AW'(ZERO_REG))) begin
      regs[wa] <= wd;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .flush    (flush),
    .pending  (pending),
    .busy_cnt (busy_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            fwd;
    logic [XLEN-1:0] data;

    assign ra   = rd_addr[i*AW +: AW];
    // A forwarded write also retires the pending bit as seen by this reader.
    assign fwd  = (BYPASS != 0) && we && (wa == ra);
    assign data = (!rst || (ra == AW'(ZERO_REG))) ? '0 :
                  fwd ? wd : regs[ra];
    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i] = rst && (ra != AW'(ZERO_REG)) && !fwd && pending[ra];
  end

endmodule
